// File: rtl/nx_stream_distributor_n_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | nx_stream_distributor_n_pkg                                        |
// | Shared types and the rotate-priority scan for the distributor.     |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package nx_stream_distributor_n_pkg;

  localparam int NX_MAX_CHANNELS = 32;

  typedef enum logic {
    UNICAST   = 1'b0,
    BROADCAST = 1'b1
  } nx_dist_mode_t;

  // Index of the first set bit scanning dir, dir+1, ... modulo channels; -1 if none.
  // Walking hops from far to near lets the nearest hop win without an early exit.
  function automatic int nx_rotate_scan(input logic [NX_MAX_CHANNELS-1:0] present,
                                        input int dir, input int channels);
    int idx;
    int k;
    idx = -1;
    for (int h = NX_MAX_CHANNELS - 1; h >= 0; h--) begin
      if (h < channels) begin
        k = dir + h;
        if (k >= channels) k = k - channels;
        if (present[k[4:0]]) idx = k;
      end
    end
    return idx;
  endfunction

endpackage
`default_nettype wire

// File: rtl/nx_dist_resolve.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | nx_dist_resolve                                                    |
// | Picks the first present channel at or after dir (one-hot).         |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module nx_dist_resolve
  import nx_stream_distributor_n_pkg::*;
#(
  parameter int CHANNELS = 4
) (
  input  logic [$clog2(CHANNELS)-1:0] dir_i,
  input  logic [CHANNELS-1:0]         present_i,
  output logic [CHANNELS-1:0]         target_o,
  output logic                        none_o
);

  logic [NX_MAX_CHANNELS-1:0] w_present_ext;
  int                         w_idx;

  always_comb begin
    w_present_ext                 = '0;
    w_present_ext[CHANNELS-1:0]   = present_i;
    w_idx                         = nx_rotate_scan(w_present_ext, int'(dir_i), CHANNELS);
    target_o                      = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (w_idx == c) target_o[c] = 1'b1;
    end
    none_o = (w_idx < 0);
  end

endmodule
`default_nettype wire

// File: rtl/nx_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | nx_fifo                                                            |
// | DEPTH-entry first-word-fall-through FIFO; push allowed when full   |
// | if a pop happens in the same cycle.                                |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module nx_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o,
  output logic             full_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_pop;
  logic             w_push;

  assign valid_o = (r_count != '0);
  assign full_o  = (r_count == CW'(DEPTH));
  assign data_o  = r_mem[r_rd_ptr];
  assign w_pop   = pop_i && valid_o;
  assign w_push  = push_i && (!full_o || w_pop);

  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wr_ptr] <= push_data_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= (r_wr_ptr == AW'(DEPTH - 1)) ? '0 : r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= (r_rd_ptr == AW'(DEPTH - 1)) ? '0 : r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/nx_stream_distributor_n.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | nx_stream_distributor_n                                            |
// | Fans one message stream out to CHANNELS buffered egress streams    |
// | with rerouting, broadcast and a saturating drop counter.           |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module nx_stream_distributor_n
  import nx_stream_distributor_n_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int DEPTH    = 2,
  parameter int WIDTH    = 32,
  parameter int COUNT_W  = 16
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  output logic                        idle_o,
  input  logic [WIDTH-1:0]            dist_data_i,
  input  logic [$clog2(CHANNELS)-1:0] dist_dir_i,
  input  logic                        dist_bcast_i,
  input  logic                        dist_valid_i,
  output logic                        dist_ready_o,
  output logic [CHANNELS*WIDTH-1:0]   egress_data_o,
  output logic [CHANNELS-1:0]         egress_valid_o,
  input  logic [CHANNELS-1:0]         egress_ready_i,
  input  logic [CHANNELS-1:0]         egress_present_i,
  output logic [COUNT_W-1:0]          drop_count_o
);

  nx_dist_mode_t       w_mode;
  logic [CHANNELS-1:0] w_fifo_full;
  logic [CHANNELS-1:0] w_pop;
  logic [CHANNELS-1:0] w_blocked;
  logic [CHANNELS-1:0] w_push;
  logic [CHANNELS-1:0] w_uni_target;
  logic                w_uni_none;
  logic [CHANNELS-1:0] w_remaining;
  logic [CHANNELS-1:0] w_done_nxt;
  logic [CHANNELS-1:0] r_done_mask;
  logic                w_ready;
  logic                w_drop;
  logic [COUNT_W-1:0]  r_drop_count;

  assign w_mode    = dist_bcast_i ? BROADCAST : UNICAST;
  assign w_pop     = egress_valid_o & egress_ready_i;
  // A full FIFO that pops this cycle still has room for a push.
  assign w_blocked = w_fifo_full & ~w_pop;

  nx_dist_resolve #(.CHANNELS(CHANNELS)) u_resolve (
    .dir_i     (dist_dir_i),
    .present_i (egress_present_i),
    .target_o  (w_uni_target),
    .none_o    (w_uni_none)
  );

  generate
    for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
      nx_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) u_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (w_push[c]),
        .push_data_i (dist_data_i),
        .pop_i       (w_pop[c]),
        .data_o      (egress_data_o[c*WIDTH +: WIDTH]),
        .valid_o     (egress_valid_o[c]),
        .full_o      (w_fifo_full[c])
      );
    end
  endgenerate

  always_comb begin
    w_push      = '0;
    w_ready     = 1'b0;
    w_drop      = 1'b0;
    w_done_nxt  = r_done_mask;
    w_remaining = egress_present_i & ~r_done_mask;
    if (dist_valid_i) begin
      case (w_mode)
        UNICAST: begin
          if (w_uni_none) begin
            w_ready = 1'b1;
            w_drop  = 1'b1;
          end else begin
            w_ready = ~|(w_uni_target & w_blocked);
            if (w_ready) w_push = w_uni_target;
          end
        end
        BROADCAST: begin
          // Only a message that reached nobody counts as dropped.
          w_push     = w_remaining & ~w_blocked;
          w_ready    = ~|(w_remaining & w_blocked);
          w_drop     = ~|egress_present_i & ~|r_done_mask;
          w_done_nxt = w_ready ? '0 : (r_done_mask | w_push);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_done_mask  <= '0;
      r_drop_count <= '0;
    end else begin
      r_done_mask <= w_done_nxt;
      if (w_drop && (r_drop_count != '1)) r_drop_count <= r_drop_count + COUNT_W'(1);
    end
  end

  assign dist_ready_o = w_ready;
  assign drop_count_o = r_drop_count;
  assign idle_o       = ~|egress_valid_o & ~dist_valid_i & ~|r_done_mask;

endmodule
`default_nettype wire
